dzcpu_useq: RTL and testbench
=============================

// Module: dzcpu_useq
// PURPOSE
//  Microcode sequencer for the DZCPU core. It fetches each macro-opcode and hands the latched byte to the
//  opcode and CB flow LUTs. It then walks a micro-PC (uPC) through the microcode ROM and decodes the
//  flow-control field of every micro-op (uop). It issues the operation/operand to the execute datapath,
//  strobes PC increments and flag updates, and handles the CB prefix and Z-conditional early end-of-flow.
// PARAMETERS
//  UOP_W   13     uop width; iUop = {flow[12:9], op[8:4], operand[3:0]}
//  FC_W    4      flow-control field width
//  OP_W    5      operation field width
//  OPND_W  4      operand field width
//  OP_JCB  5'h0C  operation code meaning "jump via CB LUT"
//  CNT_W   16     retired-instruction counter width
// PORTS
//  iClock        in   1       core clock
//  iReset        in   1       synchronous, active-high reset
//  oFetchReq     out  1       request opcode byte at current PC
//  iFetchValid   in   1       iMop valid this cycle
//  iMop          in   8       opcode byte from memory data bus
//  oMop          out  8       latched opcode, drives opcode LUT and CB LUT iMop
//  iFlowIdx      in   8       opcode LUT flow index (combinational from oMop)
//  iCbFlowIdx    in   8       CB LUT flow index (combinational from oMop)
//  oUopAddr      out  8       uPC, drives microcode ROM iAddr
//  iUop          in   UOP_W   ROM word at oUopAddr (combinational)
//  iZeroFlag     in   1       Z flag from flags register
//  iStall        in   1       datapath/memory not ready; hold current uop
//  oExecValid    out  1       oExecOp/oExecOperand valid for execute this cycle
//  oExecOp       out  OP_W    uop operation field
//  oExecOperand  out  OPND_W  uop operand field
//  oPcInc        out  1       increment PC this cycle
//  oFlagsUpdate  out  1       latch ALU flags this cycle
//  oEof          out  1       last uop of instruction issued
//  oRetired      out  CNT_W   retired-instruction count, wraps
//  oUpcOvf       out  1       sticky: uPC wrapped 255->0 without eof
// BEHAVIOUR
//  Reset: state=FETCH, uPC=0, oMop=0, oRetired=0, oUpcOvf=0; all strobes/valid=0; reset aborts any flow.
//  FSM: FETCH -> DECODE -> EXEC -> (FETCH | CBFETCH -> CBDECODE -> EXEC).
//  FETCH: oFetchReq=1 until iFetchValid; that cycle oMop<=iMop, go DECODE. Strobes are 0.
//  DECODE: 1 cycle; uPC<=iFlowIdx; go EXEC. Flow 0 (unknown opcode) is legal.
//  EXEC: oUopAddr=uPC; oExecValid=!iStall; oExecOp/oExecOperand=iUop fields.
//   With iStall=1: uPC, state and all strobes are frozen; oPcInc/oFlagsUpdate/oEof=0.
//  Flow codes (localparams; any other code behaves as OP):
//   0 OP: uPC+1 | 1 INC: PcInc, uPC+1 | 2 EOF: end | 3 INC_EOF: PcInc, end.
//   4 EOF_FU: FlagsUpdate, end | 5 INC_EOF_FU: PcInc, FlagsUpdate, end.
//   6 INC_EOF_Z: PcInc; end if iZeroFlag=1, else uPC+1.
//   7 INC_EOF_NZ: PcInc; end if iZeroFlag=0, else uPC+1.
//   8 UPD_FLAGS: FlagsUpdate, uPC+1 | 9 NOP: uPC+1.
//   For conditional codes the operation is issued regardless of the Z outcome.
//  end = oEof=1 that cycle; oRetired+1; next state FETCH; uPC<=0.
//  Operation==OP_JCB (non-stalled EXEC): flow-field strobes apply; next state CBFETCH, not uPC+1.
//   Any eof in that flow field is ignored.
//  CBFETCH: same handshake as FETCH; oMop<=CB byte. CBDECODE: uPC<=iCbFlowIdx; go EXEC.
//  CB flow index 0 (unknown CB opcode) is legal.
//  uPC arithmetic is 8-bit mod 256. On 255 -> 0 without end: oUpcOvf<=1 (sticky until reset).
//   Execution continues at 0.
//  Strobes are single-cycle, registered off state; oPcInc and oFlagsUpdate may coincide with oEof.
//  iZeroFlag is sampled in the same cycle as the conditional uop.
// TESTING
//  NOP: iMop=00, iFlowIdx=162, ROM[162]=INC_EOF -> uAddr 162 for 1 cycle; PcInc+Eof pulse; oRetired=1; FETCH.
//  JRNZ, Z=1: flow 17..19 (INC, OP, INC_EOF_Z) -> Eof at uPC 19; 3 EXEC cycles; 2 PcInc pulses.
//  JRNZ, Z=0: same flow -> uPC 19,20,21,22; Eof at 22; PcInc count 2.
//  CB 7C: iMop=CB, flow 13..15 with JCB at 15 -> CBFETCH; iMop=7C, iCbFlowIdx=16.
//   ROM[16]=EOF_FU -> FlagsUpdate+Eof at uAddr 16.
//  Stall: iStall=1 for 3 cycles at uPC 52 of CALL -> uAddr held at 52, no strobes.
//   Flow resumes at 53; total cycles +3.
//  Reset mid-flow at uPC 56 -> next cycle uPC=0, FETCH, oFetchReq=1, oRetired=0.
//  Overflow: iFlowIdx=255, ROM[255]=OP, ROM[0]=INC_EOF -> oUpcOvf=1; Eof at uAddr 0.

Source files
------------

// File: rtl/dzcpu_useq.sv
// dzcpu_useq: microcode sequencer for the DZCPU core.
// It fetches an opcode byte, resolves its flow through the opcode and CB LUTs,
// and then steps the micro-PC through the microcode ROM. Each uop is issued to
// the execute datapath, and its flow field is decoded into the PC-increment,
// flag-update and end-of-flow strobes.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_FETCH    | request opcode byte, latch it when iFetchValid
// S_DECODE   | load uPC from opcode LUT flow index
// S_EXEC     | issue uop at uPC, decode flow field, advance/end/jump-CB
// S_CBFETCH  | request CB-prefixed opcode byte, latch it when iFetchValid
// S_CBDECODE | load uPC from CB LUT flow index

module dzcpu_useq #(
    parameter int          UOP_W  = 13,
    parameter int          FC_W   = 4,
    parameter int          OP_W   = 5,
    parameter int          OPND_W = 4,
    parameter logic [4:0]  OP_JCB = 5'h0C,
    parameter int          CNT_W  = 16
) (
    input  logic              iClock,
    input  logic              iReset,
    output logic              oFetchReq,
    input  logic              iFetchValid,
    input  logic [7:0]        iMop,
    output logic [7:0]        oMop,
    input  logic [7:0]        iFlowIdx,
    input  logic [7:0]        iCbFlowIdx,
    output logic [7:0]        oUopAddr,
    input  logic [UOP_W-1:0]  iUop,
    input  logic              iZeroFlag,
    input  logic              iStall,
    output logic              oExecValid,
    output logic [OP_W-1:0]   oExecOp,
    output logic [OPND_W-1:0] oExecOperand,
    output logic              oPcInc,
    output logic              oFlagsUpdate,
    output logic              oEof,
    output logic [CNT_W-1:0]  oRetired,
    output logic              oUpcOvf
);

    localparam logic [FC_W-1:0] FC_OP         = 4'd0;
    localparam logic [FC_W-1:0] FC_INC        = 4'd1;
    localparam logic [FC_W-1:0] FC_EOF        = 4'd2;
    localparam logic [FC_W-1:0] FC_INC_EOF    = 4'd3;
    localparam logic [FC_W-1:0] FC_EOF_FU     = 4'd4;
    localparam logic [FC_W-1:0] FC_INC_EOF_FU = 4'd5;
    localparam logic [FC_W-1:0] FC_INC_EOF_Z  = 4'd6;
    localparam logic [FC_W-1:0] FC_INC_EOF_NZ = 4'd7;
    localparam logic [FC_W-1:0] FC_UPD_FLAGS  = 4'd8;
    localparam logic [FC_W-1:0] FC_NOP        = 4'd9;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_CBFETCH  = 3'd3,
        S_CBDECODE = 3'd4
    } state_t;

    state_t            state;
    logic [7:0]        upc;
    logic [FC_W-1:0]   uop_fc;
    logic [OP_W-1:0]   uop_op;
    logic [OPND_W-1:0] uop_opnd;
    logic              fc_pc_inc;
    logic              fc_flags;
    logic              fc_end;
    logic              is_jcb;
    logic              issue;

    assign uop_fc   = iUop[UOP_W-1 -: FC_W];
    assign uop_op   = iUop[OPND_W +: OP_W];
    assign uop_opnd = iUop[OPND_W-1:0];
    assign is_jcb   = (uop_op == OP_JCB);
    assign issue    = (state == S_EXEC) && !iStall;

    // Decode the flow-control field of the uop at uPC into strobe/end intents.
    always_comb begin
        fc_pc_inc = 1'b0;
        fc_flags  = 1'b0;
        fc_end    = 1'b0;
        case (uop_fc)
            FC_INC:        fc_pc_inc = 1'b1;
            FC_EOF:        fc_end    = 1'b1;
            FC_INC_EOF:    begin fc_pc_inc = 1'b1; fc_end = 1'b1; end
            FC_EOF_FU:     begin fc_flags  = 1'b1; fc_end = 1'b1; end
            FC_INC_EOF_FU: begin fc_pc_inc = 1'b1; fc_flags = 1'b1; fc_end = 1'b1; end
            FC_INC_EOF_Z:  begin fc_pc_inc = 1'b1; fc_end = iZeroFlag; end
            FC_INC_EOF_NZ: begin fc_pc_inc = 1'b1; fc_end = !iZeroFlag; end
            FC_UPD_FLAGS:  fc_flags  = 1'b1;
            FC_OP, FC_NOP: ;
            default:       ;
        endcase
    end

    // Strobes are qualified by the registered state; a stalled EXEC issues nothing.
    always_comb begin
        oFetchReq    = (state == S_FETCH) || (state == S_CBFETCH);
        oUopAddr     = upc;
        oExecValid   = issue;
        oExecOp      = uop_op;
        oExecOperand = uop_opnd;
        oPcInc       = issue && fc_pc_inc;
        oFlagsUpdate = issue && fc_flags;
        oEof         = issue && fc_end && !is_jcb;
    end

    // Sequencer FSM: fetch/decode handshakes, uPC stepping, retire count and overflow flag.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state    <= S_FETCH;
            upc      <= 8'd0;
            oMop     <= 8'd0;
            oRetired <= '0;
            oUpcOvf  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (iFetchValid) begin
                        oMop  <= iMop;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    upc   <= iFlowIdx;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (!iStall) begin
                        if (is_jcb) begin
                            // CB prefix: the flow's end code is deliberately ignored here
                            state <= S_CBFETCH;
                        end else if (fc_end) begin
                            oRetired <= oRetired + CNT_W'(1);
                            upc      <= 8'd0;
                            state    <= S_FETCH;
                        end else begin
                            upc <= upc + 8'd1;
                            if (upc == 8'hFF) begin
                                oUpcOvf <= 1'b1;
                            end
                        end
                    end
                end
                S_CBFETCH: begin
                    if (iFetchValid) begin
                        oMop  <= iMop;
                        state <= S_CBDECODE;
                    end
                end
                S_CBDECODE: begin
                    upc   <= iCbFlowIdx;
                    state <= S_EXEC;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dzcpu_useq.sv
// tb_dzcpu_useq: self-checking bench for the microcode sequencer.
// Memory, opcode LUT, CB LUT and microcode ROM are modelled as arrays.
// Directed table rows cover each flow code, hand sequences cover the multi-cycle
// corner cases, and a random phase compares against an instruction-level model.

module tb_dzcpu_useq;

    localparam logic [4:0] JCB = 5'h0C;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic        fetch_valid;
    logic [7:0]  mop_in;
    logic [7:0]  mop;
    logic [7:0]  flow_idx;
    logic [7:0]  cb_idx;
    logic [7:0]  uop_addr;
    logic [12:0] uop;
    logic        zero;
    logic        stall;
    logic        exec_valid;
    logic [4:0]  exec_op;
    logic [3:0]  exec_opnd;
    logic        pc_inc;
    logic        flags_upd;
    logic        eof;
    logic [15:0] retired;
    logic        upc_ovf;

    logic [12:0] rom   [256];
    logic [7:0]  lut   [256];
    logic [7:0]  cblut [256];

    assign uop      = rom[uop_addr];
    assign flow_idx = lut[mop];
    assign cb_idx   = cblut[mop];

    always #5 clk = ~clk;

    dzcpu_useq dut (
        .iClock       (clk),
        .iReset       (rst),
        .oFetchReq    (fetch_req),
        .iFetchValid  (fetch_valid),
        .iMop         (mop_in),
        .oMop         (mop),
        .iFlowIdx     (flow_idx),
        .iCbFlowIdx   (cb_idx),
        .oUopAddr     (uop_addr),
        .iUop         (uop),
        .iZeroFlag    (zero),
        .iStall       (stall),
        .oExecValid   (exec_valid),
        .oExecOp      (exec_op),
        .oExecOperand (exec_opnd),
        .oPcInc       (pc_inc),
        .oFlagsUpdate (flags_upd),
        .oEof         (eof),
        .oRetired     (retired),
        .oUpcOvf      (upc_ovf)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [12:0] mk(input int fc, input int op, input int opnd);
        logic [3:0] f;
        logic [4:0] o;
        logic [3:0] d;
        f = fc[3:0];
        o = op[4:0];
        d = opnd[3:0];
        return {f, o, d};
    endfunction

    // Runs one instruction from FETCH until its eof, collecting what was issued.
    task automatic run_instr(input logic [7:0] b0, input logic [7:0] b1, input logic z,
                             input int stall_addr, input int stall_len,
                             output int ex, output int pci, output int fu,
                             output int eof_addr, output int cyc, output int first_op,
                             output int stall_bad, output int held);
        int nf;
        int stalled;
        bit done;
        ex = 0; pci = 0; fu = 0; eof_addr = -1; cyc = 0; first_op = -1;
        stall_bad = 0; held = 0; nf = 0; stalled = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk); #1;
            fetch_valid = 1'b1;
            mop_in      = (nf == 0) ? b0 : b1;
            zero        = z;
            stall       = (int'(uop_addr) == stall_addr) && !fetch_req && (stalled < stall_len);
            if (stall) stalled++;
            @(negedge clk);
            cyc++;
            if (fetch_req && fetch_valid) nf++;
            if (stall) begin
                if (exec_valid || pc_inc || flags_upd || eof) stall_bad++;
                if (int'(uop_addr) == stall_addr) held++;
            end
            if (exec_valid) begin
                ex++;
                if (first_op < 0) first_op = int'(exec_op);
                pci += int'(pc_inc);
                fu  += int'(flags_upd);
                if (eof) begin
                    eof_addr = int'(uop_addr);
                    done = 1;
                end
            end
        end
        stall = 1'b0;
        fetch_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL run_instr_timeout: got no eof, expected eof within 200 cycles");
        end
    endtask

    typedef struct {
        int fc;
        bit z;
        int ex;
        int pci;
        int fu;
    } vec_t;

    typedef struct {
        int addr;
        int op;
        int opnd;
        bit pci;
        bit fu;
        bit eof;
        bit wrap;
    } rec_t;

    rec_t       q[$];
    logic [7:0] bytes [4096];
    bit         zs    [4096];
    int         mptr;

    // Expands the next instruction of the byte stream into the uops it must issue.
    task automatic model_instr();
        int a;
        int fc;
        int op;
        int steps;
        bit z;
        bit p;
        bit f;
        bit fin;
        bit more;
        logic [12:0] u;
        a = int'(lut[bytes[mptr]]);
        z = zs[mptr];
        mptr++;
        more = 1;
        steps = 0;
        while (more && steps < 2000 && mptr < 4095) begin
            steps++;
            u   = rom[a];
            fc  = int'(u[12:9]);
            op  = int'(u[8:4]);
            p   = (fc == 1) || (fc == 3) || (fc == 5) || (fc == 6) || (fc == 7);
            f   = (fc == 4) || (fc == 5) || (fc == 8);
            fin = (fc >= 2 && fc <= 5) || (fc == 6 && z) || (fc == 7 && !z);
            if (op == int'(JCB)) begin
                q.push_back('{a, op, int'(u[3:0]), p, f, 1'b0, 1'b0});
                a = int'(cblut[bytes[mptr]]);
                z = zs[mptr];
                mptr++;
            end else if (fin) begin
                q.push_back('{a, op, int'(u[3:0]), p, f, 1'b1, 1'b0});
                more = 0;
            end else begin
                q.push_back('{a, op, int'(u[3:0]), p, f, 1'b0, a == 255});
                a = (a + 1) % 256;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t vt[14];
        int ex, pci, fu, ea, cyc, fop, sbad, held;
        int cyc_ref;
        int exp_ret;
        int fptr;
        bit exp_ovf;
        bit found;
        rec_t r;

        vt[0]  = '{0, 1'b0, 2, 0, 0};
        vt[1]  = '{1, 1'b0, 2, 1, 0};
        vt[2]  = '{2, 1'b0, 1, 0, 0};
        vt[3]  = '{3, 1'b0, 1, 1, 0};
        vt[4]  = '{4, 1'b0, 1, 0, 1};
        vt[5]  = '{5, 1'b0, 1, 1, 1};
        vt[6]  = '{6, 1'b1, 1, 1, 0};
        vt[7]  = '{6, 1'b0, 2, 1, 0};
        vt[8]  = '{7, 1'b0, 1, 1, 0};
        vt[9]  = '{7, 1'b1, 2, 1, 0};
        vt[10] = '{8, 1'b0, 2, 0, 1};
        vt[11] = '{9, 1'b0, 2, 0, 0};
        vt[12] = '{12, 1'b0, 2, 0, 0};
        vt[13] = '{15, 1'b1, 2, 0, 0};

        for (int i = 0; i < 256; i++) begin
            rom[i]   = mk(2, 1, 0);
            lut[i]   = 8'd0;
            cblut[i] = 8'd0;
        end

        // reset state, with a valid fetch presented that must be ignored
        rst = 1'b1; fetch_valid = 1'b1; mop_in = 8'hAA; stall = 1'b0; zero = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fetch_req", int'(fetch_req), 1);
        check("rst_uaddr", int'(uop_addr), 0);
        check("rst_mop", int'(mop), 0);
        check("rst_retired", int'(retired), 0);
        check("rst_ovf", int'(upc_ovf), 0);
        check("rst_strobes", int'({exec_valid, pc_inc, flags_upd, eof}), 0);
        @(posedge clk); #1;
        rst = 1'b0; fetch_valid = 1'b0;

        // one row per flow code: flow at 40, plain EOF at 41
        lut[8'h10] = 8'd40;
        exp_ret = 0;
        for (int i = 0; i < 14; i++) begin
            rom[40] = mk(vt[i].fc, 16 + i, i);
            rom[41] = mk(2, 1, 0);
            run_instr(8'h10, 8'h00, vt[i].z, -1, 0, ex, pci, fu, ea, cyc, fop, sbad, held);
            exp_ret++;
            check($sformatf("vec%0d_exec", i), ex, vt[i].ex);
            check($sformatf("vec%0d_pcinc", i), pci, vt[i].pci);
            check($sformatf("vec%0d_flags", i), fu, vt[i].fu);
            check($sformatf("vec%0d_eofaddr", i), ea, (vt[i].ex == 1) ? 40 : 41);
            check($sformatf("vec%0d_op", i), fop, 16 + i);
            @(negedge clk);
            check($sformatf("vec%0d_retired", i), int'(retired), exp_ret);
        end

        // NOP through flow 162
        lut[8'h00] = 8'd162;
        rom[162]   = mk(3, 2, 0);
        run_instr(8'h00, 8'h00, 1'b0, -1, 0, ex, pci, fu, ea, cyc, fop, sbad, held);
        exp_ret++;
        check("nop_exec", ex, 1);
        check("nop_pcinc", pci, 1);
        check("nop_eofaddr", ea, 162);
        check("nop_cycles", cyc, 3);
        @(negedge clk);
        check("nop_retired", int'(retired), exp_ret);
        check("nop_back_to_fetch", int'(fetch_req), 1);

        // JRNZ flow 17..22
        lut[8'h20] = 8'd17;
        rom[17] = mk(1, 3, 0);
        rom[18] = mk(0, 4, 0);
        rom[19] = mk(6, 5, 0);
        rom[20] = mk(0, 6, 0);
        rom[21] = mk(0, 6, 1);
        rom[22] = mk(2, 7, 0);
        run_instr(8'h20, 8'h00, 1'b1, -1, 0, ex, pci, fu, ea, cyc, fop, sbad, held);
        exp_ret++;
        check("jrnz_z1_exec", ex, 3);
        check("jrnz_z1_pcinc", pci, 2);
        check("jrnz_z1_eofaddr", ea, 19);
        run_instr(8'h20, 8'h00, 1'b0, -1, 0, ex, pci, fu, ea, cyc, fop, sbad, held);
        exp_ret++;
        check("jrnz_z0_exec", ex, 6);
        check("jrnz_z0_pcinc", pci, 2);
        check("jrnz_z0_eofaddr", ea, 22);

        // CB 7C; the JCB uop carries INC_EOF whose end must be ignored
        lut[8'hCB]   = 8'd13;
        rom[13]      = mk(0, 1, 0);
        rom[14]      = mk(0, 2, 0);
        rom[15]      = mk(3, 12, 0);
        cblut[8'h7C] = 8'd16;
        rom[16]      = mk(4, 9, 3);
        run_instr(8'hCB, 8'h7C, 1'b0, -1, 0, ex, pci, fu, ea, cyc, fop, sbad, held);
        exp_ret++;
        check("cb_exec", ex, 4);
        check("cb_pcinc", pci, 1);
        check("cb_flags", fu, 1);
        check("cb_eofaddr", ea, 16);
        check("cb_cycles", cyc, 8);
        @(negedge clk);
        check("cb_retired", int'(retired), exp_ret);
        check("cb_mop", int'(mop), 8'h7C);

        // CALL with a 3-cycle stall at uPC 52
        lut[8'hCD] = 8'd50;
        rom[50] = mk(0, 1, 0);
        rom[51] = mk(0, 2, 0);
        rom[52] = mk(1, 3, 0);
        rom[53] = mk(0, 4, 0);
        rom[54] = mk(3, 5, 0);
        run_instr(8'hCD, 8'h00, 1'b0, -1, 0, ex, pci, fu, ea, cyc_ref, fop, sbad, held);
        exp_ret++;
        check("call_cycles", cyc_ref, 7);
        run_instr(8'hCD, 8'h00, 1'b0, 52, 3, ex, pci, fu, ea, cyc, fop, sbad, held);
        exp_ret++;
        check("stall_cycles", cyc, 10);
        check("stall_quiet", sbad, 0);
        check("stall_held", held, 3);
        check("stall_exec", ex, 5);
        check("stall_pcinc", pci, 2);
        check("stall_eofaddr", ea, 54);
        @(negedge clk);
        check("stall_retired", int'(retired), exp_ret);

        // reset in the middle of a flow at uPC 56
        lut[8'h30] = 8'd56;
        for (int i = 56; i < 60; i++) rom[i] = mk(0, 2, 0);
        rom[60] = mk(2, 1, 0);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            fetch_valid = 1'b1;
            mop_in = 8'h30;
            @(negedge clk);
            if (exec_valid && uop_addr == 8'd56) found = 1;
        end
        check("midrst_reached56", int'(found), 1);
        @(posedge clk); #1;
        rst = 1'b1; fetch_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_uaddr", int'(uop_addr), 0);
        check("midrst_fetch_req", int'(fetch_req), 1);
        check("midrst_retired", int'(retired), 0);
        check("midrst_exec", int'(exec_valid), 0);

        // uPC overflow 255 -> 0
        lut[8'h40] = 8'd255;
        rom[255] = mk(0, 5, 1);
        rom[0]   = mk(3, 6, 2);
        check("ovf_before", int'(upc_ovf), 0);
        run_instr(8'h40, 8'h00, 1'b0, -1, 0, ex, pci, fu, ea, cyc, fop, sbad, held);
        check("ovf_exec", ex, 2);
        check("ovf_eofaddr", ea, 0);
        check("ovf_pcinc", pci, 1);
        @(negedge clk);
        check("ovf_sticky", int'(upc_ovf), 1);
        check("ovf_retired", int'(retired), 1);

        // random programs against the instruction-level model
        @(posedge clk); #1;
        rst = 1'b1;
        for (int a = 0; a < 256; a++) begin
            int fc;
            int op;
            fc = int'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) op = int'(JCB);
            else begin
                op = int'($urandom_range(0, 31));
                if (op == int'(JCB)) op = 13;
            end
            if (a % 8 == 6) begin
                fc = 2;
                if (op == int'(JCB)) op = 1;
            end
            rom[a]   = mk(fc, op, int'($urandom_range(0, 15)));
            lut[a]   = 8'($urandom);
            cblut[a] = 8'($urandom);
        end
        for (int i = 0; i < 4096; i++) begin
            bytes[i] = 8'($urandom);
            zs[i]    = 1'($urandom);
        end
        q.delete();
        mptr = 0;
        fptr = 0;
        exp_ret = 0;
        exp_ovf = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            fetch_valid = ($urandom_range(0, 2) != 0);
            mop_in      = fetch_valid ? bytes[fptr] : 8'($urandom);
            stall       = ($urandom_range(0, 3) == 0);
            zero        = (fptr > 0) ? zs[fptr-1] : 1'($urandom);
            @(negedge clk);
            check("rnd_retired", int'(retired), exp_ret);
            check("rnd_ovf", int'(upc_ovf), int'(exp_ovf));
            if (fetch_req && fetch_valid) fptr++;
            if (stall) begin
                check("rnd_stall_quiet", int'({exec_valid, pc_inc, flags_upd, eof}), 0);
            end else if (exec_valid) begin
                if (q.size() == 0) model_instr();
                r = q.pop_front();
                check("rnd_uaddr", int'(uop_addr), r.addr);
                check("rnd_op", int'(exec_op), r.op);
                check("rnd_opnd", int'(exec_opnd), r.opnd);
                check("rnd_strobes", int'({pc_inc, flags_upd, eof}), int'({r.pci, r.fu, r.eof}));
                if (r.eof) exp_ret++;
                if (r.wrap) exp_ovf = 1'b1;
            end else begin
                check("rnd_idle_quiet", int'({pc_inc, flags_upd, eof}), 0);
            end
            if (fptr > 4000) break;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
